// File: rtl/dma_in_if.sv
// Handshake bundle for dma_in: config descriptor, crossbar stream in, memory write port out.
// master = crossbar/config/memory side, slave = the DMA channel itself.
interface dma_in_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             config_valid;
  logic             config_ready;
  logic [31:0]      config_payload_startAddr;
  logic [31:0]      config_payload_length;
  logic [31:0]      config_payload_timerInit;
  logic             config_payload_reverse;

  logic [WIDTH-1:0] t1_data;
  logic             t1_last;
  logic             t1_valid;
  logic             t1_ready;

  logic [31:0]      i0_addr;
  logic [WIDTH-1:0] i0_data;
  logic             i0_valid;
  logic             i0_ready;

  modport master (
    output config_valid, config_payload_startAddr, config_payload_length,
           config_payload_timerInit, config_payload_reverse,
    input  config_ready,
    output t1_data, t1_last, t1_valid,
    input  t1_ready,
    input  i0_addr, i0_data, i0_valid,
    output i0_ready
  );

  modport slave (
    input  config_valid, config_payload_startAddr, config_payload_length,
           config_payload_timerInit, config_payload_reverse,
    output config_ready,
    input  t1_data, t1_last, t1_valid,
    output t1_ready,
    output i0_addr, i0_data, i0_valid,
    input  i0_ready
  );
endinterface

// File: rtl/dma_in.sv
// Stream-to-memory DMA channel: buffers crossbar words in a first-word fall-through FIFO
// and writes them to consecutive addresses under control of a latched descriptor.
module dma_in #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        srst,
  dma_in_if.slave     bus,
  input  logic [31:0] ctimer,
  input  logic        dmaReset,
  output logic [31:0] status,
  output logic        strobe_complete,
  output logic        interrupt,
  input  logic        interrupt_clear
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    ACTIVE = 2'd1
  } state_t;

  state_t           state_q;
  logic [31:0]      addr_q;
  logic [31:0]      len_q;
  logic [31:0]      target_q;
  logic [31:0]      in_cnt_q;
  logic [31:0]      out_cnt_q;
  logic             reverse_q;
  logic             early_q;
  logic             strobe_q;
  logic             irq_q;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic active;
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic done;
  logic timer_hit;
  logic start;
  logic skip;

  always_comb begin
    active     = (state_q == ACTIVE);
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    bus.t1_ready = active && !fifo_full && (in_cnt_q < target_q) && !dmaReset;
    // Writes are held off during an abort so completion and abort never coincide.
    bus.i0_valid = active && !fifo_empty && !dmaReset;
    bus.i0_data  = mem_q[rd_ptr_q[AW-1:0]];
    bus.i0_addr  = addr_q;

    push = bus.t1_valid && bus.t1_ready;
    pop  = bus.i0_valid && bus.i0_ready;
    done = pop && ((out_cnt_q + 32'd1) == target_q);

    timer_hit = (ctimer == bus.config_payload_timerInit) ||
                (bus.config_payload_timerInit == '1);
    start = !active && bus.config_valid && (bus.config_payload_length != '0) && timer_hit;
    skip  = !active && bus.config_valid && (bus.config_payload_length == '0);

    bus.config_ready = skip || (active && (dmaReset || done));

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (dmaReset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    status          = {state_q, early_q, 5'b0, out_cnt_q[23:0]};
    strobe_complete = strobe_q;
    interrupt       = irq_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.t1_data;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q   <= WAIT;
      addr_q    <= '0;
      len_q     <= '0;
      target_q  <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      reverse_q <= 1'b0;
      early_q   <= 1'b0;
      strobe_q  <= 1'b0;
      irq_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      strobe_q <= done;
      irq_q    <= done || (irq_q && !interrupt_clear);

      case (state_q)
        WAIT: begin
          if (start) begin
            state_q   <= ACTIVE;
            addr_q    <= bus.config_payload_startAddr;
            len_q     <= bus.config_payload_length;
            target_q  <= bus.config_payload_length;
            reverse_q <= bus.config_payload_reverse;
            early_q   <= 1'b0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
          end
        end
        ACTIVE: begin
          if (dmaReset) begin
            state_q <= WAIT;
          end else begin
            if (push) begin
              in_cnt_q <= in_cnt_q + 32'd1;
              // A last marker before the programmed length shrinks the transfer.
              if (bus.t1_last && ((in_cnt_q + 32'd1) < len_q)) begin
                target_q <= in_cnt_q + 32'd1;
                early_q  <= 1'b1;
              end
            end
            if (pop) begin
              out_cnt_q <= out_cnt_q + 32'd1;
              addr_q    <= reverse_q ? (addr_q - 32'd1) : (addr_q + 32'd1);
            end
            if (done) state_q <= WAIT;
          end
        end
        default: state_q <= WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_in.sv
// Scoreboard bench for dma_in: accepted stream words queue their expected memory writes,
// a negedge monitor pops and compares every write the DUT issues.
module tb_dma_in;

  logic        clk = 1'b0;
  logic        srst;
  logic [31:0] ctimer;
  logic        dmaReset;
  logic        interrupt_clear;
  logic [31:0] status;
  logic        strobe_complete;
  logic        interrupt;

  always #5 clk = ~clk;

  dma_in_if #(.WIDTH(32)) ifc ();

  dma_in #(.DEPTH(32), .WIDTH(32)) dut (
    .clk             (clk),
    .srst            (srst),
    .bus             (ifc.slave),
    .ctimer          (ctimer),
    .dmaReset        (dmaReset),
    .status          (status),
    .strobe_complete (strobe_complete),
    .interrupt       (interrupt),
    .interrupt_clear (interrupt_clear)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  wr_cnt = 0;
  int  strobe_cnt = 0;
  int  acc_cnt = 0;
  int  cyc = 0;
  int  first_acc_cyc = -1;
  int  cfg_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t e;
    if (srst === 1'b0) begin
      if (ifc.i0_valid === 1'b1 && ifc.i0_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%h data=%h required=no write", ifc.i0_addr, ifc.i0_data);
        end else begin
          e = exp_q.pop_front();
          if ({ifc.i0_addr, ifc.i0_data} !== {e.addr, e.data}) begin
            errors++;
            $display("FAIL write addr=%h data=%h required addr=%h data=%h",
                     ifc.i0_addr, ifc.i0_data, e.addr, e.data);
          end
        end
        wr_cnt++;
      end
      if (strobe_complete === 1'b1) strobe_cnt++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic do_cfg(input logic [31:0] a, input logic [31:0] l, input logic [31:0] t,
                        input logic r, output bit got);
    got = 1'b0;
    ifc.config_payload_startAddr = a;
    ifc.config_payload_length    = l;
    ifc.config_payload_timerInit = t;
    ifc.config_payload_reverse   = r;
    ifc.config_valid             = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ifc.config_ready === 1'b1) begin
        got = 1'b1;
        cfg_cyc = cyc;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL cfg_timeout config_ready=0 required=1");
    end
    @(posedge clk); #1;
    ifc.config_valid = 1'b0;
  endtask

  task automatic send_words(input int n, input logic [31:0] a0, input logic [31:0] d0,
                            input int last_idx, input logic rev);
    logic [31:0] a;
    a = a0;
    for (int k = 0; k < n; k++) begin
      bit ok;
      ok = 1'b0;
      ifc.t1_valid = 1'b1;
      ifc.t1_data  = d0 + k;
      ifc.t1_last  = (k == last_idx);
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (ifc.t1_ready === 1'b1) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL stream_timeout word=%0d t1_ready=0 required=1", k);
        ifc.t1_valid = 1'b0;
        ifc.t1_last  = 1'b0;
        return;
      end
      if (first_acc_cyc < 0) first_acc_cyc = cyc;
      exp_q.push_back({a, d0 + k});
      acc_cnt++;
      a = rev ? a - 32'd1 : a + 32'd1;
      @(posedge clk); #1;
    end
    ifc.t1_valid = 1'b0;
    ifc.t1_last  = 1'b0;
  endtask

  task automatic clear_irq();
    interrupt_clear = 1'b1;
    @(posedge clk); #1;
    interrupt_clear = 1'b0;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    ifc.config_valid = 1'b0;
    ifc.config_payload_startAddr = '0;
    ifc.config_payload_length = '0;
    ifc.config_payload_timerInit = '0;
    ifc.config_payload_reverse = 1'b0;
    ifc.t1_data = '0;
    ifc.t1_last = 1'b0;
    ifc.t1_valid = 1'b0;
    ifc.i0_ready = 1'b1;
    ctimer = '0;
    dmaReset = 1'b0;
    interrupt_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    checks++; if (ifc.config_ready !== 1'b0) begin errors++; $display("FAIL reset_config_ready got=%b exp=0", ifc.config_ready); end
    checks++; if (ifc.t1_ready !== 1'b0) begin errors++; $display("FAIL reset_t1_ready got=%b exp=0", ifc.t1_ready); end
    checks++; if (ifc.i0_valid !== 1'b0) begin errors++; $display("FAIL reset_i0_valid got=%b exp=0", ifc.i0_valid); end
    checks++; if (ifc.i0_addr !== 32'h0) begin errors++; $display("FAIL reset_i0_addr got=%h exp=0", ifc.i0_addr); end
    checks++; if (strobe_complete !== 1'b0) begin errors++; $display("FAIL reset_strobe got=%b exp=0", strobe_complete); end
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL reset_interrupt got=%b exp=0", interrupt); end
    checks++; if (status !== 32'h0) begin errors++; $display("FAIL reset_status got=%h exp=0", status); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit got;
    int w0;
    w0 = wr_cnt;
    first_acc_cyc = -1;
    ifc.i0_ready = 1'b1;
    fork
      do_cfg(32'h100, 32'd4, '1, 1'b0, got);
      send_words(4, 32'h100, 32'hA000_0000, -1, 1'b0);
    join
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL basic_cfg_ready got=%b exp=1", got); end
    checks++; if (cfg_cyc - first_acc_cyc != 4) begin errors++; $display("FAIL basic_latency got=%0d exp=4", cfg_cyc - first_acc_cyc); end
    checks++; if (strobe_complete !== 1'b1) begin errors++; $display("FAIL basic_strobe got=%b exp=1", strobe_complete); end
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL basic_interrupt got=%b exp=1", interrupt); end
    checks++; if (status !== 32'h0000_0004) begin errors++; $display("FAIL basic_status got=%h exp=00000004", status); end
    checks++; if (wr_cnt - w0 != 4) begin errors++; $display("FAIL basic_writes got=%0d exp=4", wr_cnt - w0); end
    @(posedge clk); #1;
    checks++; if (strobe_complete !== 1'b0) begin errors++; $display("FAIL basic_strobe_pulse got=%b exp=0", strobe_complete); end
    checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL basic_interrupt_sticky got=%b exp=1", interrupt); end
    clear_irq();
    checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL basic_interrupt_clear got=%b exp=0", interrupt); end
  endtask

  task automatic test_reverse();
    bit got;
    fork
      do_cfg(32'h0, 32'd3, '1, 1'b1, got);
      send_words(3, 32'h0, 32'hB000_0000, -1, 1'b1);
    join
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL reverse_cfg_ready got=%b exp=1", got); end
    checks++; if (status !== 32'h0000_0003) begin errors++; $display("FAIL reverse_status got=%h exp=00000003", status); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL reverse_pending got=%0d exp=0", exp_q.size()); end
    clear_irq();
  endtask

  task automatic test_early_last();
    bit got;
    int w0;
    w0 = wr_cnt;
    fork
      do_cfg(32'h200, 32'd8, '1, 1'b0, got);
      begin
        send_words(3, 32'h200, 32'hC000_0000, 2, 1'b0);
        ifc.t1_valid = 1'b1;
        ifc.t1_data  = 32'hC000_0003;
        ifc.t1_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          checks++;
          if (ifc.t1_ready !== 1'b0) begin errors++; $display("FAIL early_fourth_word t1_ready=%b exp=0", ifc.t1_ready); end
        end
        ifc.t1_valid = 1'b0;
      end
    join
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL early_cfg_ready got=%b exp=1", got); end
    checks++; if (status !== 32'h2000_0003) begin errors++; $display("FAIL early_status got=%h exp=20000003", status); end
    checks++; if (wr_cnt - w0 != 3) begin errors++; $display("FAIL early_writes got=%0d exp=3", wr_cnt - w0); end
    clear_irq();
  endtask

  task automatic test_backpressure();
    bit got;
    int w0;
    int a0;
    w0 = wr_cnt;
    a0 = acc_cnt;
    ifc.i0_ready = 1'b0;
    fork
      do_cfg(32'h2000, 32'd40, '1, 1'b0, got);
      send_words(40, 32'h2000, 32'hD000_0000, -1, 1'b0);
      begin
        repeat (50) @(posedge clk);
        @(negedge clk);
        checks++; if (acc_cnt - a0 != 32) begin errors++; $display("FAIL bp_accepted got=%0d exp=32", acc_cnt - a0); end
        checks++; if (ifc.t1_ready !== 1'b0) begin errors++; $display("FAIL bp_t1_ready got=%b exp=0", ifc.t1_ready); end
        checks++; if ({ifc.i0_valid, ifc.i0_addr, ifc.i0_data} !== {1'b1, 32'h2000, 32'hD000_0000}) begin
          errors++;
          $display("FAIL bp_stalled_head valid=%b addr=%h data=%h exp 1 00002000 d0000000",
                   ifc.i0_valid, ifc.i0_addr, ifc.i0_data);
        end
        checks++; if (wr_cnt != w0) begin errors++; $display("FAIL bp_no_writes got=%0d exp=0", wr_cnt - w0); end
        @(posedge clk); #1;
        ifc.i0_ready = 1'b1;
      end
    join
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL bp_cfg_ready got=%b exp=1", got); end
    checks++; if (status !== 32'h0000_0028) begin errors++; $display("FAIL bp_status got=%h exp=00000028", status); end
    checks++; if (wr_cnt - w0 != 40) begin errors++; $display("FAIL bp_writes got=%0d exp=40", wr_cnt - w0); end
    clear_irq();
  endtask

  task automatic test_timer();
    bit got;
    bit started;
    logic [31:0] st_tm;
    int w0;
    int s0;
    started = 1'b0;
    st_tm = '0;
    ctimer = 32'd90;
    fork
      do_cfg(32'h400, 32'd2, 32'd100, 1'b0, got);
      send_words(2, 32'h400, 32'hE000_0000, -1, 1'b0);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (status[31:30] == 2'd1) begin
          started = 1'b1;
          st_tm = ctimer;
          break;
        end
        @(posedge clk); #1;
        ctimer = ctimer + 32'd1;
      end
    join
    checks++; if (started !== 1'b1 || st_tm !== 32'd101) begin
      errors++; $display("FAIL timer_start started=%b ctimer_after=%0d exp started=1 ctimer_after=101", started, st_tm);
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL timer_cfg_ready got=%b exp=1", got); end
    clear_irq();
    w0 = wr_cnt;
    s0 = strobe_cnt;
    do_cfg(32'h500, 32'd0, 32'd100, 1'b0, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL zero_len_cfg_ready got=%b exp=1", got); end
    checks++; if ({strobe_complete, interrupt} !== 2'b00) begin
      errors++; $display("FAIL zero_len_flags strobe=%b interrupt=%b exp 0 0", strobe_complete, interrupt);
    end
    checks++; if (status !== 32'h0000_0002) begin errors++; $display("FAIL zero_len_status got=%h exp=00000002", status); end
    @(posedge clk); #1;
    checks++; if (wr_cnt != w0 || strobe_cnt != s0) begin
      errors++; $display("FAIL zero_len_activity writes=%0d strobes=%0d exp 0 0", wr_cnt - w0, strobe_cnt - s0);
    end
  endtask

  task automatic test_dma_reset();
    bit got;
    int w0;
    int s0;
    w0 = wr_cnt;
    s0 = strobe_cnt;
    ifc.i0_ready = 1'b0;
    fork
      do_cfg(32'h600, 32'd6, '1, 1'b0, got);
      begin
        send_words(6, 32'h600, 32'hF000_0000, -1, 1'b0);
        ifc.i0_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ifc.i0_ready = 1'b0;
        @(posedge clk); #1;
        dmaReset = 1'b1;
        @(negedge clk);
        checks++; if ({ifc.config_ready, ifc.t1_ready, ifc.i0_valid} !== 3'b100) begin
          errors++; $display("FAIL abort_handshake cfg_ready=%b t1_ready=%b i0_valid=%b exp 1 0 0",
                             ifc.config_ready, ifc.t1_ready, ifc.i0_valid);
        end
        @(posedge clk); #1;
        dmaReset = 1'b0;
        @(negedge clk);
        checks++; if (status !== 32'h0000_0002) begin errors++; $display("FAIL abort_status got=%h exp=00000002", status); end
        checks++; if ({strobe_complete, interrupt, ifc.i0_valid} !== 3'b000) begin
          errors++; $display("FAIL abort_flags strobe=%b interrupt=%b i0_valid=%b exp 0 0 0",
                             strobe_complete, interrupt, ifc.i0_valid);
        end
      end
    join
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL abort_cfg_ready got=%b exp=1", got); end
    checks++; if (wr_cnt - w0 != 2 || exp_q.size() != 4 || strobe_cnt != s0) begin
      errors++; $display("FAIL abort_counts writes=%0d pending=%0d strobes=%0d exp 2 4 0",
                         wr_cnt - w0, exp_q.size(), strobe_cnt - s0);
    end
    exp_q.delete();
    w0 = wr_cnt;
    ifc.i0_ready = 1'b1;
    fork
      do_cfg(32'h700, 32'd2, '1, 1'b0, got);
      send_words(2, 32'h700, 32'h1234_0000, -1, 1'b0);
    join
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL after_abort_cfg_ready got=%b exp=1", got); end
    checks++; if (status !== 32'h0000_0002 || interrupt !== 1'b1) begin
      errors++; $display("FAIL after_abort_done status=%h interrupt=%b exp 00000002 1", status, interrupt);
    end
    checks++; if (wr_cnt - w0 != 2 || exp_q.size() != 0) begin
      errors++; $display("FAIL after_abort_writes writes=%0d pending=%0d exp 2 0", wr_cnt - w0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reverse();
    test_early_last();
    test_backpressure();
    test_timer();
    test_dma_reset();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
